input_mem: RTL and testbench

//  Read-side counterpart of the rotate engine's output buffer. Collects 32-bit AHB read words (HRDATA)
//  for one 8x8 pixel tile and unpacks them into a 192-byte buffer. Serves the B, G and R bytes of any

---
 rtl/rotate_pkg.sv | 19 +
 rtl/imem_byte_ram.sv | 77 +++++++
 rtl/input_mem.sv | 153 +++++++++++++++
 tb/tb_input_mem.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared constants and IMEM state encoding for the rotate engine buffers.
package rotate_pkg;

    localparam int PIX_BYTES  = 3;
    localparam int WORD_BYTES = 4;
    localparam int NPIX_DEF   = 64;

    typedef enum logic [1:0] {
        IMEM_EMPTY = 2'd0,
        IMEM_FILL  = 2'd1,
        IMEM_FULL  = 2'd2
    } imem_state_t;

    // Number of 32-bit bus words that make up one tile of npix pixels.
    function automatic int imem_nwords(input int npix);
        return (PIX_BYTES * npix) / WORD_BYTES;
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// Tile byte store: 4-byte word write port, registered 3-byte pixel read port.
module imem_byte_ram
    import rotate_pkg::*;
#(
    parameter int NPIX = NPIX_DEF,
    parameter int AW   = 6,
    parameter int CW   = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [CW-1:0] i_wr_word,
    input  logic [31:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_pix,
    output logic [7:0]    o_rd_b,
    output logic [7:0]    o_rd_g,
    output logic [7:0]    o_rd_r,
    output logic          o_rd_valid
);

    localparam int NBYTES = PIX_BYTES * NPIX;
    localparam int BW     = $clog2(NBYTES);
    localparam logic [AW:0] NPIX_L = NPIX[AW:0];

    logic [7:0]    r_mem [NBYTES];
    logic [BW-1:0] w_wr_base;
    logic [BW-1:0] w_rd_base;
    logic          w_rd_in_range;
    logic [7:0]    r_b;
    logic [7:0]    r_g;
    logic [7:0]    r_r;
    logic          r_valid;

    always_comb begin
        w_wr_base     = BW'(i_wr_word) * BW'(WORD_BYTES);
        w_rd_base     = BW'(i_rd_pix) * BW'(PIX_BYTES);
        w_rd_in_range = ({1'b0, i_rd_pix} < NPIX_L);
    end

    // Storage is deliberately not reset; a tile is always refilled before use.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                r_mem[w_wr_base + BW'(j)] <= i_wr_data[8*j +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_b     <= 8'h00;
            r_g     <= 8'h00;
            r_r     <= 8'h00;
        end else if (i_rd_en) begin
            r_valid <= 1'b1;
            if (w_rd_in_range) begin
                r_b <= r_mem[w_rd_base];
                r_g <= r_mem[w_rd_base + BW'(1)];
                r_r <= r_mem[w_rd_base + BW'(2)];
            end else begin
                r_b <= 8'h00;
                r_g <= 8'h00;
                r_r <= 8'h00;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_rd_b     = r_b;
    assign o_rd_g     = r_g;
    assign o_rd_r     = r_r;
    assign o_rd_valid = r_valid;

endmodule

// File: rtl/input_mem.sv
// Tile input buffer for the rotate engine: AHB read words in, B/G/R pixels out.
// Optional sticky protocol-error flag O_IMEM_ERR is built when IMEM_ERR_EN is defined.
module input_mem
    import rotate_pkg::*;
#(
    parameter int NPIX = NPIX_DEF,
    parameter int AW   = 6,
    parameter int CW   = 6
) (
    input  logic          I_IMEM_HCLK,
    input  logic          I_IMEM_HRESET,
    input  logic          I_IMEM_START,
    input  logic [31:0]   I_IMEM_RDATA,
    input  logic          I_IMEM_RVALID,
    input  logic          I_IMEM_RD_EN,
    input  logic [AW-1:0] I_IMEM_RD_ADDR,
    input  logic          I_IMEM_RELEASE,
    output logic [7:0]    O_IMEM_PIXEL_B,
    output logic [7:0]    O_IMEM_PIXEL_G,
    output logic [7:0]    O_IMEM_PIXEL_R,
    output logic          O_IMEM_PIXEL_VALID,
    output logic          O_IMEM_FULL,
`ifdef IMEM_ERR_EN
    output logic          O_IMEM_ERR,
`endif
    output logic [CW-1:0] O_IMEM_WORD_CNT
);

    localparam int          NWORDS    = imem_nwords(NPIX);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    imem_state_t   r_state;
    imem_state_t   w_state_nxt;
    logic          r_full;
    logic [CW-1:0] r_word_cnt;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_release;

    // State register; FULL is kept as its own flop so the port is registered.
    always_ff @(posedge I_IMEM_HCLK) begin
        if (I_IMEM_HRESET) begin
            r_state <= IMEM_EMPTY;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= (w_state_nxt == IMEM_FULL);
        end
    end

    // Next state: START restarts the fill from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (I_IMEM_START) begin
            w_state_nxt = IMEM_FILL;
        end else begin
            case (r_state)
                IMEM_EMPTY: w_state_nxt = IMEM_EMPTY;
                IMEM_FILL: begin
                    if (w_wr_en && (r_word_cnt == LAST_WORD)) begin
                        w_state_nxt = IMEM_FULL;
                    end else begin
                        w_state_nxt = IMEM_FILL;
                    end
                end
                IMEM_FULL: begin
                    if (I_IMEM_RELEASE) begin
                        w_state_nxt = IMEM_EMPTY;
                    end else begin
                        w_state_nxt = IMEM_FULL;
                    end
                end
                default: w_state_nxt = IMEM_EMPTY;
            endcase
        end
    end

    // Output decode: writes only in FILL (START drops the word), reads/release only in FULL.
    always_comb begin
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IMEM_FILL: w_wr_en = I_IMEM_RVALID && !I_IMEM_START;
            IMEM_FULL: begin
                w_rd_en   = I_IMEM_RD_EN;
                w_release = I_IMEM_RELEASE;
            end
            default: begin
                w_wr_en   = 1'b0;
                w_rd_en   = 1'b0;
                w_release = 1'b0;
            end
        endcase
    end

    // Word counter doubles as the write word index.
    always_ff @(posedge I_IMEM_HCLK) begin
        if (I_IMEM_HRESET) begin
            r_word_cnt <= {CW{1'b0}};
        end else if (I_IMEM_START || w_release) begin
            r_word_cnt <= {CW{1'b0}};
        end else if (w_wr_en) begin
            r_word_cnt <= r_word_cnt + CW'(1);
        end
    end

`ifdef IMEM_ERR_EN
    logic r_err;
    logic w_err_evt;

    always_comb begin
        w_err_evt = (I_IMEM_RVALID  && (r_state != IMEM_FILL)) ||
                    (I_IMEM_RD_EN   && (r_state != IMEM_FULL)) ||
                    (I_IMEM_RELEASE && (r_state != IMEM_FULL));
    end

    // Sticky error flag, cleared only by reset or a new tile.
    always_ff @(posedge I_IMEM_HCLK) begin
        if (I_IMEM_HRESET) begin
            r_err <= 1'b0;
        end else if (I_IMEM_START) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign O_IMEM_ERR = r_err;
`endif

    imem_byte_ram #(
        .NPIX (NPIX),
        .AW   (AW),
        .CW   (CW)
    ) u_ram (
        .i_clk      (I_IMEM_HCLK),
        .i_rst      (I_IMEM_HRESET),
        .i_wr_en    (w_wr_en),
        .i_wr_word  (r_word_cnt),
        .i_wr_data  (I_IMEM_RDATA),
        .i_rd_en    (w_rd_en),
        .i_rd_pix   (I_IMEM_RD_ADDR),
        .o_rd_b     (O_IMEM_PIXEL_B),
        .o_rd_g     (O_IMEM_PIXEL_G),
        .o_rd_r     (O_IMEM_PIXEL_R),
        .o_rd_valid (O_IMEM_PIXEL_VALID)
    );

    assign O_IMEM_FULL     = r_full;
    assign O_IMEM_WORD_CNT = r_word_cnt;

endmodule

// File: tb/tb_input_mem.sv
// Self-checking bench for input_mem: randomized fills/reads against a byte-array tile model.
module tb_input_mem;

    localparam int NPIX   = 64;
    localparam int AW     = 6;
    localparam int CW     = 6;
    localparam int NWORDS = 48;
    localparam int NBYTES = 192;

    logic          clk = 1'b0;
    logic          hreset;
    logic          start;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rel;
    logic [7:0]    pix_b;
    logic [7:0]    pix_g;
    logic [7:0]    pix_r;
    logic          pix_valid;
    logic          full;
    logic [CW-1:0] word_cnt;
`ifdef IMEM_ERR_EN
    logic          err;
`endif

    logic [7:0] ref_mem [NBYTES];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input_mem #(.NPIX(NPIX), .AW(AW), .CW(CW)) dut (
        .I_IMEM_HCLK        (clk),
        .I_IMEM_HRESET      (hreset),
        .I_IMEM_START       (start),
        .I_IMEM_RDATA       (rdata),
        .I_IMEM_RVALID      (rvalid),
        .I_IMEM_RD_EN       (rd_en),
        .I_IMEM_RD_ADDR     (rd_addr),
        .I_IMEM_RELEASE     (rel),
        .O_IMEM_PIXEL_B     (pix_b),
        .O_IMEM_PIXEL_G     (pix_g),
        .O_IMEM_PIXEL_R     (pix_r),
        .O_IMEM_PIXEL_VALID (pix_valid),
        .O_IMEM_FULL        (full),
`ifdef IMEM_ERR_EN
        .O_IMEM_ERR         (err),
`endif
        .O_IMEM_WORD_CNT    (word_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; rvalid = 1'b0; rd_en = 1'b0; rel = 1'b0;
        rdata = 32'h0; rd_addr = '0;
    endtask

    // Fill one tile; pat selects the {4k+3..4k} pattern, gap = idle cycles before each word.
    task automatic do_fill(input bit do_start, input bit pat, input int gap);
        logic [31:0] w;
        if (do_start) begin
            start = 1'b1; tick(); start = 1'b0;
            n_vec++;
            if (word_cnt !== '0 || full !== 1'b0) begin
                n_err++; $display("FAIL fill_start cnt=%0d full=%b want cnt=0 full=0", word_cnt, full);
            end
        end
        for (int k = 0; k < NWORDS; k++) begin
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0; rdata = $urandom; tick();
                n_vec++;
                if (word_cnt !== CW'(k)) begin
                    n_err++; $display("FAIL fill_gap_cnt got %0d want %0d", word_cnt, k);
                end
            end
            if (pat) w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            else     w = $urandom;
            rvalid = 1'b1; rdata = w; tick(); rvalid = 1'b0;
            for (int j = 0; j < 4; j++) ref_mem[4*k+j] = w[8*j +: 8];
            n_vec++;
            if (word_cnt !== CW'(k+1) || full !== (k == NWORDS-1)) begin
                n_err++; $display("FAIL fill_word k=%0d cnt=%0d full=%b want cnt=%0d full=%b",
                                  k, word_cnt, full, k+1, (k == NWORDS-1));
            end
        end
    endtask

    // Single read checked against the tile model.
    task automatic do_read(input int a);
        rd_en = 1'b1; rd_addr = AW'(a); tick(); rd_en = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b1 || pix_b !== ref_mem[3*a] || pix_g !== ref_mem[3*a+1] ||
            pix_r !== ref_mem[3*a+2]) begin
            n_err++;
            $display("FAIL read addr=%0d got v=%b bgr=%h,%h,%h want v=1 bgr=%h,%h,%h", a, pix_valid,
                     pix_b, pix_g, pix_r, ref_mem[3*a], ref_mem[3*a+1], ref_mem[3*a+2]);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        hreset = 1'b1; tick(); tick();
        n_vec++;
        if (full !== 1'b0 || word_cnt !== '0 || pix_valid !== 1'b0 ||
            pix_b !== 8'h00 || pix_g !== 8'h00 || pix_r !== 8'h00) begin
            n_err++; $display("FAIL reset full=%b cnt=%0d v=%b bgr=%h,%h,%h want all 0",
                              full, word_cnt, pix_valid, pix_b, pix_g, pix_r);
        end
        hreset = 1'b0; tick();
    endtask

    task automatic test_fill_read();
        do_fill(1'b1, 1'b1, 0);
        rd_en = 1'b1; rd_addr = AW'(5); tick(); rd_en = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b1 || pix_b !== 8'h0F || pix_g !== 8'h10 || pix_r !== 8'h11) begin
            n_err++; $display("FAIL read5 got v=%b bgr=%h,%h,%h want 1 0f,10,11", pix_valid, pix_b, pix_g, pix_r);
        end
        tick();
        n_vec++;
        if (pix_valid !== 1'b0 || pix_b !== 8'h0F) begin
            n_err++; $display("FAIL read_hold got v=%b b=%h want v=0 b=0f", pix_valid, pix_b);
        end
        rd_en = 1'b1; rd_addr = AW'(63); tick(); rd_en = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b1 || pix_b !== 8'hBD || pix_g !== 8'hBE || pix_r !== 8'hBF) begin
            n_err++; $display("FAIL read63 got v=%b bgr=%h,%h,%h want 1 bd,be,bf", pix_valid, pix_b, pix_g, pix_r);
        end
        for (int i = 0; i < 8; i++) do_read(int'($urandom_range(0, NPIX-1)));
    endtask

    task automatic test_back_to_back();
        int a;
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, NPIX-1));
            do_read(a);
            rd_en = 1'b1;
        end
        rd_en = 1'b0; tick();
        n_vec++;
        if (pix_valid !== 1'b0 || pix_b !== ref_mem[3*a]) begin
            n_err++; $display("FAIL b2b_end got v=%b b=%h want v=0 b=%h", pix_valid, pix_b, ref_mem[3*a]);
        end
    endtask

    task automatic test_restart();
        logic [31:0] w;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            rvalid = 1'b1; rdata = w; tick();
            for (int j = 0; j < 4; j++) ref_mem[4*k+j] = w[8*j +: 8];
        end
        start = 1'b1; rvalid = 1'b1; rdata = $urandom; tick();
        start = 1'b0; rvalid = 1'b0;
        n_vec++;
        if (word_cnt !== '0 || full !== 1'b0) begin
            n_err++; $display("FAIL restart cnt=%0d full=%b want 0 0", word_cnt, full);
        end
        do_fill(1'b0, 1'b0, 0);
        for (int p = 0; p < NPIX; p++) do_read(p);
    endtask

    task automatic test_gapped();
        do_fill(1'b1, 1'b1, 2);
        for (int i = 0; i < 12; i++) do_read(int'($urandom_range(0, NPIX-1)));
    endtask

    task automatic test_release_race();
        rd_en = 1'b1; rd_addr = '0; rel = 1'b1; tick();
        rd_en = 1'b0; rel = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b1 || pix_b !== 8'h00 || pix_g !== 8'h01 || pix_r !== 8'h02 ||
            full !== 1'b0 || word_cnt !== '0) begin
            n_err++; $display("FAIL release_race v=%b bgr=%h,%h,%h full=%b cnt=%0d want 1 00,01,02 0 0",
                              pix_valid, pix_b, pix_g, pix_r, full, word_cnt);
        end
        rd_en = 1'b1; rd_addr = AW'(5); tick(); rd_en = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b0 || pix_b !== 8'h00) begin
            n_err++; $display("FAIL read_after_release v=%b b=%h want v=0 b=00", pix_valid, pix_b);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = $urandom; rd_en = 1'b1; rd_addr = AW'($urandom); rel = 1'b1; tick();
            n_vec++;
            if (pix_valid !== 1'b0 || word_cnt !== '0 || full !== 1'b0) begin
                n_err++; $display("FAIL illegal_empty v=%b cnt=%0d full=%b want 0 0 0", pix_valid, word_cnt, full);
            end
        end
        idle_inputs();
`ifdef IMEM_ERR_EN
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", err); end
`endif
        start = 1'b1; tick(); start = 1'b0;
`ifdef IMEM_ERR_EN
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", err); end
`endif
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1; rd_addr = AW'($urandom); tick();
            n_vec++;
            if (pix_valid !== 1'b0 || word_cnt !== '0) begin
                n_err++; $display("FAIL illegal_fill v=%b cnt=%0d want 0 0", pix_valid, word_cnt);
            end
        end
        rd_en = 1'b0;
        do_fill(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = $urandom; tick();
        end
        rvalid = 1'b0;
        n_vec++;
        if (word_cnt !== CW'(NWORDS) || full !== 1'b1) begin
            n_err++; $display("FAIL rvalid_in_full cnt=%0d full=%b want 48 1", word_cnt, full);
        end
        for (int p = 0; p < NPIX; p++) do_read(p);
`ifdef IMEM_ERR_EN
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_full got %b want 1", err); end
`endif
    endtask

    task automatic test_reset_squash();
        rd_en = 1'b1; rd_addr = AW'(7); hreset = 1'b1; tick();
        rd_en = 1'b0; hreset = 1'b0;
        n_vec++;
        if (pix_valid !== 1'b0 || full !== 1'b0 || word_cnt !== '0 || pix_b !== 8'h00) begin
            n_err++; $display("FAIL reset_read v=%b full=%b cnt=%0d b=%h want 0 0 0 00",
                              pix_valid, full, word_cnt, pix_b);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin rvalid = 1'b1; rdata = $urandom; tick(); end
        rvalid = 1'b0; hreset = 1'b1; tick(); hreset = 1'b0;
        n_vec++;
        if (word_cnt !== '0 || full !== 1'b0) begin
            n_err++; $display("FAIL reset_fill cnt=%0d full=%b want 0 0", word_cnt, full);
        end
        rvalid = 1'b1; rdata = $urandom; tick(); rvalid = 1'b0;
        n_vec++;
        if (word_cnt !== '0) begin
            n_err++; $display("FAIL reset_to_empty cnt=%0d want 0", word_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        hreset = 1'b1;
        test_reset();
        test_fill_read();
        test_back_to_back();
        test_restart();
        test_gapped();
        test_release_race();
        test_illegal();
        test_reset_squash();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
